// File: rtl/ham_pkg.sv
// ham_pkg: shared sizing, position mapping and classification for the SECDED decoder.
// Contents: ham_cls_e (CLEAN/SINGLE/DOUBLE), ham_par_w, ham_code_w, ham_data_pos.
package ham_pkg;

   typedef enum logic [1:0] {CLEAN, SINGLE, DOUBLE} ham_cls_e;

   // Smallest r with 2^r >= data_w + r + 1
   function automatic int ham_par_w(input int data_w);
      int r;
      r = 1;
      while ((1 << r) < data_w + r + 1) r++;
      return r;
   endfunction

   // Hamming positions plus the overall parity bit
   function automatic int ham_code_w(input int data_w);
      return data_w + ham_par_w(data_w) + 1;
   endfunction

   // Hamming position (1-based) of data bit idx: idx-th non-power-of-two position from 3 upward
   function automatic int ham_data_pos(input int idx);
      int n;
      int pos;
      n = 0;
      pos = 0;
      for (int p = 3; p < 128; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (n == idx) pos = p;
            n++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/ham_syndrome.sv
// ham_syndrome: combinational syndrome and overall parity of a SECDED codeword.
// Ports: cw (codeword, bit i-1 = position i, MSB = overall parity), s (syndrome {c_r..c1}), p (XOR of all bits).
module ham_syndrome import ham_pkg::*; #(
   parameter int DATA_W = 4,
   localparam int PAR_W = ham_par_w(DATA_W),
   localparam int CODE_W = DATA_W + PAR_W + 1
) (
   input  logic [CODE_W-1:0] cw,
   output logic [PAR_W-1:0]  s,
   output logic              p
);

   always_comb begin
      s = '0;
      for (int i = 1; i < CODE_W; i++)
         for (int k = 0; k < PAR_W; k++)
            if (i[k]) s[k] = s[k] ^ cw[i-1];
      p = ^cw;
   end

endmodule

// File: rtl/ham_secded_decoder.sv
// ham_secded_decoder: 2-stage pipelined Hamming SECDED decoder with saturating error counters.
// Ports: clk/rst_n (sync active-low), in_valid/in_ready/enc_ham_data/correct_en (input word),
//        out_valid/out_ready/data/pos_error/error/error_dbl (decoded word), cnt_clr/corr_cnt/uncorr_cnt (counters).
module ham_secded_decoder import ham_pkg::*; #(
   parameter int DATA_W = 4,
   parameter int CNT_W = 16,
   localparam int PAR_W = ham_par_w(DATA_W),
   localparam int CODE_W = ham_code_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] enc_ham_data,
   input  logic              correct_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data,
   output logic [PAR_W-1:0]  pos_error,
   output logic              error,
   output logic              error_dbl,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   logic en, hs, par;
   logic v1_q, v1_d, ce1_q, ce1_d;
   logic [CODE_W-1:0] cw1_q, cw1_d, cw_fix;
   logic [PAR_W-1:0] syn, pos_error_q, pos_error_d;
   logic out_valid_q, out_valid_d, error_q, error_d, error_dbl_q, error_dbl_d;
   logic [DATA_W-1:0] data_q, data_d, data_x;
   logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
   ham_cls_e cls;

   ham_syndrome #(.DATA_W(DATA_W)) u_syn (.cw(cw1_q), .s(syn), .p(par));

   assign en = !out_valid_q || out_ready;
   assign hs = out_valid_q && out_ready;
   assign in_ready = en;

   always_comb begin
      // odd parity with an in-range syndrome is a single error; s=0 there means the parity bit itself
      cls = (syn == '0 && !par) ? CLEAN : (par && int'(syn) < CODE_W) ? SINGLE : DOUBLE;
      cw_fix = cw1_q;
      for (int i = 1; i < CODE_W; i++)
         if (cls == SINGLE && ce1_q && syn == PAR_W'(i)) cw_fix[i-1] = ~cw1_q[i-1];
      data_x = '0;
      for (int j = 0; j < DATA_W; j++)
         data_x[j] = cw_fix[ham_data_pos(j)-1];
      v1_d = en ? in_valid : v1_q;
      cw1_d = en ? enc_ham_data : cw1_q;
      ce1_d = en ? correct_en : ce1_q;
      out_valid_d = en ? v1_q : out_valid_q;
      data_d = en ? data_x : data_q;
      pos_error_d = en ? syn : pos_error_q;
      error_d = en ? cls == SINGLE : error_q;
      error_dbl_d = en ? cls == DOUBLE : error_dbl_q;
      corr_cnt_d = cnt_clr ? '0 : (hs && error_q && corr_cnt_q != '1) ? corr_cnt_q + 1'b1 : corr_cnt_q;
      uncorr_cnt_d = cnt_clr ? '0 : (hs && error_dbl_q && uncorr_cnt_q != '1) ? uncorr_cnt_q + 1'b1 : uncorr_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         cw1_q <= '0;
         ce1_q <= 1'b0;
         out_valid_q <= 1'b0;
         data_q <= '0;
         pos_error_q <= '0;
         error_q <= 1'b0;
         error_dbl_q <= 1'b0;
         corr_cnt_q <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         v1_q <= v1_d;
         cw1_q <= cw1_d;
         ce1_q <= ce1_d;
         out_valid_q <= out_valid_d;
         data_q <= data_d;
         pos_error_q <= pos_error_d;
         error_q <= error_d;
         error_dbl_q <= error_dbl_d;
         corr_cnt_q <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign data = data_q;
   assign pos_error = pos_error_q;
   assign error = error_q;
   assign error_dbl = error_dbl_q;
   assign corr_cnt = corr_cnt_q;
   assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_ham_secded_decoder.sv
// tb_ham_secded_decoder: table vectors, directed corner sequences and a randomized stream against a reference model.
module tb_ham_secded_decoder;

   localparam int DW = 4;
   localparam int CW = 8;
   localparam int PW = 3;
   localparam int CNTW = 2;
   localparam int CMAX = (1 << CNTW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [CW-1:0] enc_ham_data = '0;
   logic correct_en = 1'b0;
   logic out_valid;
   logic out_ready = 1'b1;
   logic [DW-1:0] data;
   logic [PW-1:0] pos_error;
   logic error, error_dbl;
   logic cnt_clr = 1'b0;
   logic [CNTW-1:0] corr_cnt, uncorr_cnt;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [PW-1:0] pos;
      logic err;
      logic dbl;
   } exp_t;

   typedef struct {
      logic [CW-1:0] cw;
      logic ce;
      exp_t e;
      int corr;
      int uncorr;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;
   exp_t q[$];
   logic mon_en = 1'b0;
   int m_corr = 0;
   int m_uncorr = 0;
   int dpos [DW] = '{3, 5, 6, 7};

   always #5 clk = ~clk;

   ham_secded_decoder #(.DATA_W(DW), .CNT_W(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .enc_ham_data(enc_ham_data), .correct_en(correct_en), .out_valid(out_valid),
      .out_ready(out_ready), .data(data), .pos_error(pos_error), .error(error),
      .error_dbl(error_dbl), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // syndrome as the XOR of the indices of all set Hamming positions
   function automatic int syn_of(input logic [CW-1:0] cw);
      int s;
      s = 0;
      for (int i = 1; i < CW; i++) if (cw[i-1]) s ^= i;
      return s;
   endfunction

   function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
      logic [CW-1:0] cw;
      int s;
      cw = '0;
      for (int j = 0; j < DW; j++) cw[dpos[j]-1] = d[j];
      s = syn_of(cw);
      for (int k = 0; k < PW; k++) cw[(1 << k) - 1] = s[k];
      cw[CW-1] = ^cw[CW-2:0];
      return cw;
   endfunction

   function automatic exp_t model(input logic [CW-1:0] cw, input logic ce);
      exp_t e;
      int s;
      logic p;
      logic [CW-1:0] c;
      s = syn_of(cw);
      p = ^cw;
      c = cw;
      e.pos = PW'(s);
      e.err = p && s < CW;
      e.dbl = (!p && s != 0) || (p && s >= CW);
      if (e.err && ce && s != 0) c[s-1] = ~c[s-1];
      for (int j = 0; j < DW; j++) e.d[j] = c[dpos[j]-1];
      return e;
   endfunction

   function automatic logic [CW-1:0] rand_word();
      logic [CW-1:0] cw;
      int n;
      cw = encode(DW'($urandom));
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) cw[$urandom_range(0, CW-1)] ^= 1'b1;
      return cw;
   endfunction

   // scoreboard: outputs must match the oldest accepted word whenever out_valid is high
   always @(negedge clk) begin
      if (mon_en) begin
         chk("corr_cnt", corr_cnt, m_corr);
         chk("uncorr_cnt", uncorr_cnt, m_uncorr);
         chk("in_ready", in_ready, !(out_valid && !out_ready));
         if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
               chk("data", data, q[0].d);
               chk("pos_error", pos_error, q[0].pos);
               chk("error", error, q[0].err);
               chk("error_dbl", error_dbl, q[0].dbl);
            end
         end
         if (cnt_clr) begin
            m_corr = 0;
            m_uncorr = 0;
         end else if (out_valid && out_ready && q.size() != 0) begin
            if (q[0].err && m_corr < CMAX) m_corr++;
            if (q[0].dbl && m_uncorr < CMAX) m_uncorr++;
         end
         if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
         if (in_valid && in_ready) q.push_back(model(enc_ham_data, correct_en));
      end
   end

   task automatic send(input logic [CW-1:0] cw, input logic ce);
      int t;
      t = 0;
      in_valid = 1'b1;
      enc_ham_data = cw;
      correct_en = ce;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 50 && (q.size() != 0 || out_valid); c++) @(negedge clk);
      chk("drain_left", q.size(), 0);
      chk("drain_valid", out_valid, 0);
   endtask

   task automatic clear_counters();
      @(posedge clk);
      #1 cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t tbl[8];
      tbl[0] = '{8'h55, 1'b1, '{4'hB, 3'd0, 1'b0, 1'b0}, 0, 0};
      tbl[1] = '{8'h45, 1'b1, '{4'hB, 3'd5, 1'b1, 1'b0}, 1, 0};
      tbl[2] = '{8'h45, 1'b0, '{4'h9, 3'd5, 1'b1, 1'b0}, 2, 0};
      tbl[3] = '{8'hD5, 1'b1, '{4'hB, 3'd0, 1'b1, 1'b0}, 3, 0};
      tbl[4] = '{8'h56, 1'b1, '{4'hB, 3'd3, 1'b0, 1'b1}, 3, 1};
      tbl[5] = '{8'hD5, 1'b0, '{4'hB, 3'd0, 1'b1, 1'b0}, 3, 1};
      tbl[6] = '{8'h00, 1'b1, '{4'h0, 3'd0, 1'b0, 1'b0}, 3, 1};
      tbl[7] = '{8'h15, 1'b1, '{4'hB, 3'd7, 1'b1, 1'b0}, 3, 1};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data", data, 0);
      chk("rst_pos_error", pos_error, 0);
      chk("rst_error", error, 0);
      chk("rst_error_dbl", error_dbl, 0);
      chk("rst_corr", corr_cnt, 0);
      chk("rst_uncorr", uncorr_cnt, 0);
      chk("rst_in_ready", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         enc_ham_data = tbl[i].cw;
         correct_en = tbl[i].ce;
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
         chk("tbl_early_valid", out_valid, 0);
         @(negedge clk);
         chk("tbl_valid", out_valid, 1);
         chk("tbl_data", data, tbl[i].e.d);
         chk("tbl_pos", pos_error, tbl[i].e.pos);
         chk("tbl_err", error, tbl[i].e.err);
         chk("tbl_dbl", error_dbl, tbl[i].e.dbl);
         @(negedge clk);
         chk("tbl_corr", corr_cnt, tbl[i].corr);
         chk("tbl_uncorr", uncorr_cnt, tbl[i].uncorr);
      end

      clear_counters();
      m_corr = 0;
      m_uncorr = 0;
      q.delete();
      mon_en = 1'b1;

      fork
         begin
            for (int i = 0; i < 4; i++) send(rand_word(), 1'($urandom));
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready, 0);
               @(posedge clk);
            end
            #1 out_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'($urandom_range(0, 1));
         enc_ham_data = rand_word();
         correct_en = 1'($urandom_range(0, 1));
         out_ready = $urandom_range(0, 3) != 0;
         cnt_clr = $urandom_range(0, 15) == 0;
      end
      in_valid = 1'b0;
      cnt_clr = 1'b0;
      out_ready = 1'b1;
      drain();

      clear_counters();
      for (int i = 0; i < 5; i++) send(8'h45, 1'b1);
      drain();
      chk("corr_sat", corr_cnt, CMAX);

      send(8'h45, 1'b1);
      @(posedge clk);
      #1;
      chk("clr_hs_valid", out_valid, 1);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1 cnt_clr = 1'b0;
      @(negedge clk);
      chk("clr_priority", corr_cnt, 0);
      send(8'h56, 1'b1);
      drain();

      mon_en = 1'b0;
      q.delete();
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      enc_ham_data = 8'h45;
      correct_en = 1'b1;
      @(posedge clk);
      #1 enc_ham_data = 8'h56;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("flight_rst_valid", out_valid, 0);
      chk("flight_rst_corr", corr_cnt, 0);
      chk("flight_rst_uncorr", uncorr_cnt, 0);
      chk("flight_rst_error", error, 0);
      chk("flight_rst_in_ready", in_ready, 1);
      @(negedge clk);
      chk("flight_discard", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ham_secded_decoder.md
HAM_SECDED_DECODER -- requirements
Module: ham_secded_decoder

Interface
REQ-001 Parameter DATA_W, default 4, data bits per codeword (2..64).
REQ-002 Parameter CNT_W, default 16, width of each error counter.
REQ-003 Derived constant PAR_W: minimal r with 2^r >= DATA_W+r+1; CODE_W = DATA_W+PAR_W+1.
REQ-004 One clock; reset is synchronous and active-low (clk, rst_n).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  enc_ham_data holds a codeword.
REQ-008 in_ready  output  1  block accepts a codeword this cycle.
REQ-009 enc_ham_data  input  CODE_W  codeword; bit i-1 = Hamming position i (i=1..CODE_W-1); bit CODE_W-1 = overall parity.
REQ-010 correct_en  input  1  1 = correct single errors, 0 = detect only; sampled with the accepted word.
REQ-011 out_valid  output  1  output word present.
REQ-012 out_ready  input  1  consumer accepts the output word.
REQ-013 data  output  DATA_W  decoded data; data[0] at the lowest non-power-of-two position, ascending.
REQ-014 pos_error  output  PAR_W  syndrome {c_r..c1}; 0 = no position error.
REQ-015 error  output  1  single-error flag (corrected, or correctable when correct_en=0).
REQ-016 error_dbl  output  1  uncorrectable-error flag.
REQ-017 cnt_clr  input  1  synchronous clear of both counters.
REQ-018 corr_cnt, uncorr_cnt  output  CNT_W each  saturating error counters.

Function
REQ-019 The block SHALL be a 2-stage pipeline: S1 registers the codeword and correct_en; S2 registers the syndrome, classification and data.
REQ-020 Advance: en = !out_valid || out_ready; in_ready = en; both stages advance only when en=1.
REQ-021 Latency SHALL be 2 cycles from input handshake to out_valid with no stall; with out_ready held high, throughput SHALL be 1 word/cycle.
REQ-022 Outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Syndrome bit c_k = XOR of all positions whose index has bit k set; p = XOR of all CODE_W bits.
REQ-024 Classification: s=0,p=0 -> clean; p=1, 1<=s<=CODE_W-1 -> single at position s; p=1, s=0 -> single in the overall parity bit, data untouched; p=1, s>CODE_W-1 -> error_dbl; s!=0, p=0 -> error_dbl.
REQ-025 On a single error with correct_en=1, the bit at position s SHALL be flipped before data extraction; with correct_en=0, data SHALL be extracted raw and error still asserted.
REQ-026 On error_dbl, data SHALL be extracted raw; error=0.
REQ-027 error and error_dbl SHALL never both be 1.
REQ-028 corr_cnt increments on an output handshake with error=1; uncorr_cnt increments on an output handshake with error_dbl=1; both saturate at all-ones.
REQ-029 cnt_clr=1 SHALL zero both counters and take priority over a same-cycle increment.

Reset
REQ-030 rst_n=0 at a clock edge SHALL clear both stage-valid flags, out_valid, data, pos_error, error, error_dbl, corr_cnt and uncorr_cnt to 0.
REQ-031 Words in flight at reset SHALL be discarded; in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-032 A shared package ham_pkg SHALL hold the PAR_W/CODE_W computation function, the position-to-data-index mapping function and the classification enum {CLEAN, SINGLE, DOUBLE}.
REQ-033 A combinational sub-module ham_syndrome (codeword -> s, p) SHALL be instantiated in S2; all registers stay in ham_secded_decoder.

Verification (DATA_W=4, CODE_W=8; clean codeword for data 4'hB is 8'h55)
REQ-034 8'h55, correct_en=1 -> 2 cycles later data=4'hB, pos_error=0, error=0, error_dbl=0.
REQ-035 8'h45 (position 5 flipped), correct_en=1 -> data=4'hB, pos_error=5, error=1, corr_cnt=1; same input with correct_en=0 -> data=4'h9, error=1.
REQ-036 8'hD5 (parity bit flipped) -> data=4'hB, pos_error=0, error=1; 8'h56 (positions 1 and 2 flipped) -> pos_error=3, error_dbl=1, error=0, uncorr_cnt=1.
REQ-037 Stream of 4 words with out_ready low for 3 cycles mid-stream -> no loss or duplication, in_ready=0 while stalled, output order preserved.
REQ-038 CNT_W=2, 5 single errors -> corr_cnt stops at 3; cnt_clr coincident with an error handshake -> corr_cnt=0. rst_n low with 2 words in flight -> out_valid=0 and counters=0 the next cycle.
